vram_arbiter: RTL and testbench

Single-port video-RAM arbiter that shares one synchronous VRAM between the vcard scanout reader and the VM8088 CPU bus. It sits between `vcard` (read-only requester) and the CPU memory decoder (read/write requester), issuing one registered RAM access per cycle. Video has priority, and a starvation guard bounds CPU wait. Read data is returned to the issuing requester through a tagged three-cycle pipeline.

---
 rtl/vram_arbiter.sv | 97 +++++++++
 tb/tb_vram_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one synchronous single-port VRAM between the video
// scanout reader and the CPU bus, one registered access per cycle.
//   clock/reset          system clock, asynchronous active-high reset
//   vid_req/vid_address  video read request (held until vid_gnt)
//   vid_gnt              combinational accept for video
//   vid_rdata/vid_rvalid video read return, 3 cycles after accept
//   cpu_req/cpu_we/cpu_address/cpu_wdata  CPU read/write request
//   cpu_gnt              combinational accept for CPU
//   cpu_rdata/cpu_rvalid CPU read return, 3 cycles after accept
//   ram_address/ram_wdata/ram_we  registered RAM command
//   ram_rdata            RAM read data, one cycle after the address
// Define VRAM_ARBITER_STARVE_EN to enable the CPU starvation guard, which
// forces a CPU grant after CPU_WAIT refused cycles; without it video has
// strict priority.
module vram_arbiter #(
    parameter int AW       = 17,
    parameter int DW       = 8,
    parameter int CPU_WAIT = 7
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_address,
    output logic          vid_gnt,
    output logic [DW-1:0] vid_rdata,
    output logic          vid_rvalid,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_address,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_rvalid,
    output logic [AW-1:0] ram_address,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_we,
    input  logic [DW-1:0] ram_rdata
);
    if (CPU_WAIT < 1 || CPU_WAIT > 255) begin : g_bad_wait
        $error("CPU_WAIT must be in 1..255");
    end
    logic force_grant;
    logic vid_acc, cpu_acc;
    logic tag0_v, tag0_cpu, tag1_v, tag1_cpu;
`ifdef VRAM_ARBITER_STARVE_EN
    logic [7:0] starve;
    assign force_grant = starve == 8'(CPU_WAIT);
    // Counts consecutive refused cycles of a pending CPU request, saturating.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            starve <= '0;
        else if (cpu_req & ~cpu_gnt)
            starve <= force_grant ? starve : starve + 8'd1;
        else
            starve <= '0;
    end
`else
    assign force_grant = 1'b0;
`endif
    assign vid_gnt = vid_req & ~force_grant & ~reset;
    assign cpu_gnt = cpu_req & (~vid_req | force_grant) & ~reset;
    assign vid_acc = vid_req & vid_gnt;
    assign cpu_acc = cpu_req & cpu_gnt;
    // Tags follow each read through the RAM's address and data stages so the
    // returning data is steered to the requester that issued it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ram_address <= '0;
            ram_wdata   <= '0;
            ram_we      <= 1'b0;
            tag0_v      <= 1'b0;
            tag0_cpu    <= 1'b0;
            tag1_v      <= 1'b0;
            tag1_cpu    <= 1'b0;
            vid_rdata   <= '0;
            vid_rvalid  <= 1'b0;
            cpu_rdata   <= '0;
            cpu_rvalid  <= 1'b0;
        end else begin
            if (vid_acc | cpu_acc)
                ram_address <= cpu_acc ? cpu_address : vid_address;
            if (cpu_acc)
                ram_wdata <= cpu_wdata;
            ram_we     <= cpu_acc & cpu_we;
            tag0_v     <= vid_acc | (cpu_acc & ~cpu_we);
            tag0_cpu   <= cpu_acc;
            tag1_v     <= tag0_v;
            tag1_cpu   <= tag0_cpu;
            vid_rvalid <= tag1_v & ~tag1_cpu;
            cpu_rvalid <= tag1_v & tag1_cpu;
            if (tag1_v & ~tag1_cpu)
                vid_rdata <= ram_rdata;
            if (tag1_v & tag1_cpu)
                cpu_rdata <= ram_rdata;
        end
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: randomized and directed scoreboard bench for vram_arbiter.
module tb_vram_arbiter;
    localparam int AW = 17, DW = 8, CPU_WAIT = 7;
`ifdef VRAM_ARBITER_STARVE_EN
    localparam bit STARVE_EN = 1'b1;
`else
    localparam bit STARVE_EN = 1'b0;
`endif
    logic clock = 1'b0, reset = 1'b1;
    logic vid_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] vid_address = '0, cpu_address = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic vid_gnt, vid_rvalid, cpu_gnt, cpu_rvalid, ram_we;
    logic [DW-1:0] vid_rdata, cpu_rdata, ram_wdata, ram_rdata;
    logic [AW-1:0] ram_address;

    vram_arbiter #(.AW(AW), .DW(DW), .CPU_WAIT(CPU_WAIT)) dut (
        .clock(clock), .reset(reset),
        .vid_req(vid_req), .vid_address(vid_address), .vid_gnt(vid_gnt),
        .vid_rdata(vid_rdata), .vid_rvalid(vid_rvalid),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_address(cpu_address),
        .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata),
        .cpu_rvalid(cpu_rvalid), .ram_address(ram_address),
        .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
    );

    always #5 clock = ~clock;

    typedef struct { logic [DW-1:0] data; int due; } exp_t;
    exp_t vid_q[$], cpu_q[$];
    int we_q[$];
    int checks = 0, errors = 0, cyc = 0, waited = 0;
    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic [DW-1:0] mdl [0:(1<<AW)-1];

    // Environment: synchronous read-first VRAM.
    always @(posedge clock) begin
        if (ram_we) ram[ram_address] <= ram_wdata;
        ram_rdata <= ram[ram_address];
    end

    always @(posedge clock) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s cycle=%0d", name, cyc);
    endtask

    // Reference model: arbitration rule, memory contents, expected returns.
    always @(negedge clock) begin
        if (reset)
            waited = 0;
        else begin
            bit starved, exp_vid, exp_cpu;
            starved = STARVE_EN && waited == CPU_WAIT;
            exp_vid = vid_req && !starved;
            exp_cpu = cpu_req && (!vid_req || starved);
            chk("vid_gnt", vid_gnt, exp_vid);
            chk("cpu_gnt", cpu_gnt, exp_cpu);
            if (vid_req && vid_gnt)
                vid_q.push_back('{mdl[vid_address], cyc + 3});
            if (cpu_req && cpu_gnt) begin
                if (cpu_we) begin
                    mdl[cpu_address] = cpu_wdata;
                    we_q.push_back(cyc);
                end else
                    cpu_q.push_back('{mdl[cpu_address], cyc + 3});
            end
            waited = (cpu_req && !exp_cpu) ? (waited < CPU_WAIT ? waited + 1 : waited) : 0;
        end
    end

    // Monitor: pops expectations whenever the DUT presents a response.
    always @(negedge clock) begin
        if (reset) begin
            chk("rst_ram_address", ram_address, 0);
            chk("rst_ram_wdata", ram_wdata, 0);
            chk("rst_ram_we", ram_we, 0);
            chk("rst_vid_rdata", vid_rdata, 0);
            chk("rst_vid_rvalid", vid_rvalid, 0);
            chk("rst_cpu_rdata", cpu_rdata, 0);
            chk("rst_cpu_rvalid", cpu_rvalid, 0);
            chk("rst_vid_gnt", vid_gnt, 0);
            chk("rst_cpu_gnt", cpu_gnt, 0);
        end else begin
            bit exp_we;
            exp_t e;
            exp_we = we_q.size() > 0 && we_q[0] == cyc - 1;
            if (exp_we) void'(we_q.pop_front());
            chk("ram_we", ram_we, exp_we);
            if (vid_rvalid) begin
                if (vid_q.size() == 0) fail_now("vid_rvalid_spurious");
                else begin
                    e = vid_q.pop_front();
                    chk("vid_rdata", vid_rdata, e.data);
                    chk("vid_latency", cyc, e.due);
                end
            end
            if (cpu_rvalid) begin
                if (cpu_q.size() == 0) fail_now("cpu_rvalid_spurious");
                else begin
                    e = cpu_q.pop_front();
                    chk("cpu_rdata", cpu_rdata, e.data);
                    chk("cpu_latency", cyc, e.due);
                end
            end
            while (vid_q.size() > 0 && vid_q[0].due < cyc) begin
                fail_now("vid_rvalid_missing");
                void'(vid_q.pop_front());
            end
            while (cpu_q.size() > 0 && cpu_q[0].due < cyc) begin
                fail_now("cpu_rvalid_missing");
                void'(cpu_q.pop_front());
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic vid_issue(input logic [AW-1:0] a);
        bit got = 0;
        vid_req = 1'b1;
        vid_address = a;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clock);
            got = vid_gnt;
        end
        if (!got) fail_now("vid_grant_timeout");
        @(posedge clock);
        #1;
        vid_req = 1'b0;
    endtask

    task automatic cpu_issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, output int w);
        bit got = 0;
        w = 0;
        cpu_req = 1'b1;
        cpu_we = we;
        cpu_address = a;
        cpu_wdata = d;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clock);
            got = cpu_gnt;
            if (!got) w++;
        end
        if (!got) fail_now("cpu_grant_timeout");
        @(posedge clock);
        #1;
        cpu_req = 1'b0;
    endtask

    initial begin
        int w;
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i] = DW'(i + 'h10);
            mdl[i] = DW'(i + 'h10);
        end
        idle(3);
        reset = 1'b0;
        // CPU write then read of the same word
        cpu_issue(1'b1, 'h00100, 8'h5A, w);
        cpu_issue(1'b0, 'h00100, 8'h00, w);
        idle(5);
        // Video burst over addresses 0..7
        for (int i = 0; i < 8; i++) vid_issue(AW'(i));
        idle(5);
        // Contention: continuous video against one CPU read
        fork
            for (int i = 0; i < 20; i++) vid_issue(AW'(i + 32));
            begin
                int cw;
                cpu_issue(1'b0, 'h00040, 8'h00, cw);
                chk("cpu_wait_cycles", cw, STARVE_EN ? CPU_WAIT : 20);
            end
        join
        idle(5);
        // Interleave CPU writes with a video read of the same top address
        for (int k = 0; k < 4; k++) begin
            fork
                cpu_issue(1'b1, 'h1FFFF, 8'hA5 ^ 8'(k), w);
                begin
                    idle(1);
                    vid_issue('h1FFFF);
                end
            join
        end
        idle(5);
        // Random traffic over a small address window to force collisions
        fork
            for (int i = 0; i < 150; i++) begin
                idle($urandom_range(0, 2));
                vid_issue(AW'($urandom_range(0, 15)));
            end
            for (int i = 0; i < 150; i++) begin
                int cw;
                idle($urandom_range(0, 2));
                cpu_issue(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom), cw);
            end
        join
        idle(6);
        // Reset the cycle after a video accept: the read must never return
        vid_issue('h00005);
        reset = 1'b1;
        vid_req = 1'b1;
        vid_address = 'h00009;
        vid_q.delete();
        cpu_q.delete();
        we_q.delete();
        idle(1);
        reset = 1'b0;
        vid_req = 1'b0;
        idle(10);
        chk("vid_q_drained", vid_q.size(), 0);
        chk("cpu_q_drained", cpu_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cycle=%0d", cyc);
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule
